aes_inv_key_schedule: RTL
=========================

# aes_inv_key_schedule

Round-key source for the AES-128 decryption datapath. Accepts the cipher key, runs the forward schedule byte-serially up to the round-10 key, then walks backward one round per request, presenting round keys 10, 9, …, 0 in the order the inverse cipher consumes them. One shared `SubBytes` instance serves both directions, so no 11-entry key store is needed.

## Interface
- No parameters. AES-128 only; Rcon table is fixed: 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `key_load` in 1: one-cycle pulse; captures `key_in` as the round-0 key and starts the forward sweep.
- `key_in` in 128: cipher key. Word w0 = [127:96] … w3 = [31:0]; MSB byte first within each word.
- `next_req` in 1: request the previous round key. Honoured only while `key_valid`=1 and `round_o`>0.
- `round_key_o` out 128: current round key, same word/byte layout as `key_in`.
- `round_o` out 4: round index of `round_key_o`.
- `key_valid` out 1: `round_key_o`/`round_o` are stable and usable.
- `busy` out 1: a forward or inverse step is in progress.

## Operation
- States: IDLE, FWD, READY, INV. Step counter `cnt` runs 0..4 in FWD and INV.
- Each round step takes 5 cycles:
  - cnt 0..3: `SubBytes` on byte `cnt` of RotWord(t), where byte 0 is the MSB. The result is registered into g[cnt].
  - cnt 4: g[0] ^= Rcon, then the new words are written.
- FWD, producing round r+1 from round r:
  - t = w3.
  - w0' = w0^g; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Rcon index is r+1.
- INV, producing round r-1 from round r:
  - t = w3^w2, formed combinationally from the held registers.
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0; w0' = w0^g.
  - Rcon index is r.
- RotWord([a0 a1 a2 a3]) = [a1 a2 a3 a0].
- Key registers change only on the cnt-4 edge; they hold during cnt 0..3.
- Transitions:
  - IDLE → FWD on `key_load`.
  - FWD → FWD after each step until `round_o`=10, then → READY.
  - READY → INV on `next_req` when `round_o`>0.
  - INV → READY after one step.
- `key_load` in any state: reloads `key_in`, sets `round_o`=0 and `cnt`=0, enters FWD, and drops `key_valid`.
  - Simultaneous `key_load` and `next_req`: load wins.
- `next_req` is ignored (no error) in any of these cases:
  - in IDLE, FWD or INV;
  - in READY with `round_o`=0.
- After round 0 is reached, the block stays in READY with round 0 until the next `key_load`.

## Timing
- Reset values: `round_key_o`=0, `round_o`=0, `key_valid`=0, `busy`=0, g=0, `cnt`=0, state IDLE.
  - Reset mid-sweep aborts all work with the same values.
- Forward sweep, with `key_load` sampled at edge E0:
  - FWD cycles run from E0 to E50.
  - `round_o` increments at E5, E10, …, E50; intermediate keys appear on `round_key_o` but `key_valid` stays 0.
  - At E50: `key_valid`=1, `busy`=0, `round_o`=10.
- Inverse step, with `next_req` sampled at edge N0:
  - `key_valid`=0 and `busy`=1 from N0.
  - At N0+5: new key, `round_o` decremented, `key_valid`=1.
- Back-to-back requests are possible: holding `next_req` high yields one key per 6-cycle period (1 READY cycle + 5 INV cycles).
- `busy` and `key_valid` are never both 1.
- The `SubBytes` path is combinational; g[cnt] is registered the same cycle.

## Test plan
- Reset, then idle 10 cycles → all outputs 0. Pulse `next_req` → no change.
- FIPS-197 key `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `key_load`:
  - at E5, `round_key_o`=a0fafe1788542cb123a339392a6c7605;
  - at E50, `key_valid`=1, `round_o`=10, key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same key, one `next_req` after READY → 5 cycles later `round_o`=9, key=ac7766f319fadc2128d12941575c006e.
- Same key, `next_req` held high → rounds 9..0 on a 6-cycle period:
  - the final key equals 2b7e151628aed2a6abf7158809cf4f3c with `round_o`=0;
  - further requests are ignored.
- All-zero key:
  - round 1 = 62636363626363636263636362636363;
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e;
  - full backward walk returns all-zero.
- `key_load` at E23 of a sweep with a new key → restarts: `round_o`=0 immediately, round-10 valid 50 cycles later with the new key's values.
  - Also `rst` asserted mid-INV → all outputs 0 next cycle.

Source files
------------

// File: rtl/aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_key_schedule
// Purpose  : AES-128 round-key source for the inverse cipher. The forward
//            schedule runs byte-serially up to round 10. Each request then
//            walks back one round, so keys appear in the order 10, 9, ..., 0.
//            One S-box serves both directions, so no 11-entry key store is
//            needed.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_key_schedule (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_load,
   input  logic [127:0] key_in,
   input  logic         next_req,
   output logic [127:0] round_key_o,
   output logic [3:0]   round_o,
   output logic         key_valid,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FWD   = 2'd1,
      S_READY = 2'd2,
      S_INV   = 2'd3
   } state_t;

   // AES forward S-box, entry i at index i
   localparam logic [0:255][7:0] C_SBOX = {
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   // Rcon by round index 1..10; unused slots are padded with zero
   localparam logic [0:15][7:0] C_RCON = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   state_t         state_q, state_d;
   logic [2:0]     cnt_q,   cnt_d;
   logic [127:0]   key_q,   key_d;
   logic [3:0]     round_q, round_d;
   logic [31:0]    g_q,     g_d;
   logic           valid_q, valid_d;
   logic           busy_q,  busy_d;

   logic [31:0]    w_w0, w_w1, w_w2, w_w3;
   logic [31:0]    w_t, w_rot, w_g_fin;
   logic [31:0]    w_f0, w_f1, w_f2, w_f3;
   logic [7:0]     w_sel, w_sb;
   logic [3:0]     w_rcon_idx;
   logic [127:0]   w_fwd_key, w_inv_key;

   assign w_w0 = key_q[127:96];
   assign w_w1 = key_q[95:64];
   assign w_w2 = key_q[63:32];
   assign w_w3 = key_q[31:0];

   // Going backward, the old w3 is recovered as w3^w2 of the held round key
   assign w_t   = (state_q == S_INV) ? (w_w3 ^ w_w2) : w_w3;
   assign w_rot = {w_t[23:0], w_t[31:24]};
   assign w_sb  = C_SBOX[w_sel];

   // Forward uses Rcon of the round being produced; inverse uses the current one
   assign w_rcon_idx = (state_q == S_INV) ? round_q : (round_q + 4'd1);
   assign w_g_fin    = g_q ^ {C_RCON[w_rcon_idx], 24'h000000};

   assign w_f0      = w_w0 ^ w_g_fin;
   assign w_f1      = w_w1 ^ w_f0;
   assign w_f2      = w_w2 ^ w_f1;
   assign w_f3      = w_w3 ^ w_f2;
   assign w_fwd_key = {w_f0, w_f1, w_f2, w_f3};
   assign w_inv_key = {w_w0 ^ w_g_fin, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};

   // Pick byte cnt of RotWord(t) as the S-box input, byte 0 being the MSB
   always_comb begin
      w_sel = w_rot[31:24];
      case (cnt_q[1:0])
         2'd0:    w_sel = w_rot[31:24];
         2'd1:    w_sel = w_rot[23:16];
         2'd2:    w_sel = w_rot[15:8];
         default: w_sel = w_rot[7:0];
      endcase
   end

   // Next-state: load override, 5-cycle round steps, request handling
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      round_d = round_q;
      g_d     = g_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      if (key_load) begin
         state_d = S_FWD;
         key_d   = key_in;
         round_d = 4'd0;
         cnt_d   = 3'd0;
         valid_d = 1'b0;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            S_FWD, S_INV: begin
               if (cnt_q != 3'd4) begin
                  case (cnt_q[1:0])
                     2'd0:    g_d[31:24] = w_sb;
                     2'd1:    g_d[23:16] = w_sb;
                     2'd2:    g_d[15:8]  = w_sb;
                     default: g_d[7:0]   = w_sb;
                  endcase
                  cnt_d = cnt_q + 3'd1;
               end else begin
                  cnt_d = 3'd0;
                  if (state_q == S_FWD) begin
                     key_d   = w_fwd_key;
                     round_d = round_q + 4'd1;
                     if (round_q == 4'd9) begin
                        state_d = S_READY;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                     end
                  end else begin
                     key_d   = w_inv_key;
                     round_d = round_q - 4'd1;
                     state_d = S_READY;
                     valid_d = 1'b1;
                     busy_d  = 1'b0;
                  end
               end
            end
            S_READY: begin
               if (next_req && (round_q != 4'd0)) begin
                  state_d = S_INV;
                  cnt_d   = 3'd0;
                  valid_d = 1'b0;
                  busy_d  = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         key_q   <= 128'd0;
         round_q <= 4'd0;
         g_q     <= 32'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         round_q <= round_d;
         g_q     <= g_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign round_key_o = key_q;
   assign round_o     = round_q;
   assign key_valid   = valid_q;
   assign busy        = busy_q;

endmodule
`default_nettype wire
